// File: rtl/mult_if.sv
// mult_if: control bus between the multiplier FSM and the switch/datapath side.
//   run, clear_a_load_b, m      : requests and B LSB into the FSM
//   clr_a_load_b, clr_a, ld_a,
//   sub, shift, busy, done      : strobes and status out of the FSM
interface mult_if;
  logic run, clear_a_load_b, m;
  logic clr_a_load_b, clr_a, ld_a, sub, shift, busy, done;
  modport master(output run, clear_a_load_b, m, input clr_a_load_b, clr_a, ld_a, sub, shift, busy, done);
  modport slave(input run, clear_a_load_b, m, output clr_a_load_b, clr_a, ld_a, sub, shift, busy, done);
endinterface

// File: rtl/mult_control.sv
// mult_control: add/shift signed multiplier control FSM.
//   clk, rst (async active-high) plain ports; all other signals on mult_if.slave.
//   Optional macro MULT_SKIP_ADD_EN: an ADD cycle with m=0 shifts directly.
module mult_control #(parameter int NBITS = 8) (
  input logic clk,
  input logic rst,
  mult_if.slave bus
);
  localparam int CW = $clog2(NBITS + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic last, skip;
  assign last = cnt == CW'(NBITS - 1);
`ifdef MULT_SKIP_ADD_EN
  assign skip = state == ADD && !bus.m;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == CLEAR ? '0 : (state == SHIFT || skip) ? cnt + 1'b1 : cnt;
    end
  always_comb
    case (state)
      IDLE: nxt = bus.run ? CLEAR : IDLE;
      CLEAR: nxt = ADD;
      ADD: nxt = skip ? (last ? DONE : ADD) : SHIFT;
      SHIFT: nxt = last ? DONE : ADD;
      DONE: nxt = bus.run ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  // Sub only on the final add, which subtracts the sign-weighted multiplicand.
  always_comb begin
    bus.clr_a_load_b = state == IDLE && bus.clear_a_load_b;
    bus.clr_a = state == CLEAR;
    bus.ld_a = state == ADD && bus.m;
    bus.sub = state == ADD && bus.m && last;
    bus.shift = state == SHIFT || skip;
    bus.busy = state == CLEAR || state == ADD || state == SHIFT;
    bus.done = state == DONE;
  end
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: random and directed checks of mult_control against an iteration-level model.
module tb_mult_control;
  localparam int N = 8;
`ifdef MULT_SKIP_ADD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  mult_if bus();
  mult_control #(.NBITS(N)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int n_ld, n_sub, n_sh;
  logic [7:0] sv = 8'h00, sw = 8'h00, dp_a = 8'h00, dp_b = 8'h00;
  logic dp_x = 1'b0;
  logic [8:0] sx;
  bit force_m = 1'b0;
  assign sx = {sv[7], sv};
  assign bus.m = force_m | dp_b[0];
  always @(posedge clk) cyc <= cyc + 1;
  // Reference A:X:B datapath driven by the DUT strobes.
  always @(posedge clk)
    if (bus.clr_a_load_b) begin
      dp_x <= 1'b0;
      dp_a <= 8'h00;
      dp_b <= sw;
    end else if (bus.clr_a) begin
      dp_x <= 1'b0;
      dp_a <= 8'h00;
    end else if (bus.ld_a)
      {dp_x, dp_a} <= {dp_a[7], dp_a} + (bus.sub ? -sx : sx);
    else if (bus.shift) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  // Model: mode 0 idle, 1 running (it=-1 clear, else iteration it, ph 0 add / 1 shift), 2 done.
  int mode = 0, it = 0, ph = 0, p;
  bit pchk = 1'b1;
  logic [15:0] exp_p;
  always @(negedge clk) begin : cmp
    logic [6:0] e, a;
    if (rst) mode = 0;
    e = '0;
    if (mode == 0) e[6] = bus.clear_a_load_b;
    else if (mode == 2) e[0] = 1'b1;
    else if (it < 0) e = 7'b0100010;
    else if (ph == 0) begin
      e[4] = bus.m;
      e[3] = bus.m && it == N - 1;
      e[2] = SKIP && !bus.m;
      e[1] = 1'b1;
    end else e[2:1] = 2'b11;
    a = {bus.clr_a_load_b, bus.clr_a, bus.ld_a, bus.sub, bus.shift, bus.busy, bus.done};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL ctl cyc %0d: got %b expected %b", cyc, a, e);
    end
    if (mode == 2 && !pchk) begin
      pchk = 1'b1;
      chk("product", {dp_a, dp_b}, exp_p);
    end
    if (!rst)
      if (mode == 0) begin
        if (bus.run) begin
          mode = 1;
          it = -1;
          pchk = force_m;
        end
      end else if (mode == 2) begin
        if (!bus.run) mode = 0;
      end else if (it < 0) begin
        p = $signed(sv) * $signed(dp_b);
        exp_p = p[15:0];
        it = 0;
        ph = 0;
      end else if (ph == 0 && (bus.m || !SKIP)) ph = 1;
      else if (it == N - 1) mode = 2;
      else begin
        it++;
        ph = 0;
      end
  end
  function automatic int exp_lat(input logic [7:0] b, input bit fm);
    return SKIP ? 1 + N + (fm ? N : $countones(b)) : 1 + 2 * N;
  endfunction
  // rel<0: hold run 20 cycles past done; else drop run after rel samples.
  task automatic do_mult(input logic [7:0] s_in, input logic [7:0] b_in, input int rel, input bit fm,
                         output int lat, output logic [15:0] res);
    int t0;
    @(posedge clk); #1;
    sv = s_in;
    sw = b_in;
    force_m = fm;
    bus.clear_a_load_b = 1'b1;
    @(posedge clk); #1;
    bus.clear_a_load_b = 1'b0;
    bus.run = 1'b1;
    t0 = -1;
    lat = -1;
    n_ld = 0;
    n_sub = 0;
    n_sh = 0;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.clr_a) t0 = cyc;
      n_ld += int'(bus.ld_a);
      n_sub += int'(bus.sub);
      n_sh += int'(bus.shift);
      if (bus.done) lat = cyc - t0;
      if (c == rel) bus.run = 1'b0;
      if (rel >= 0 && lat < 0) bus.clear_a_load_b = 1'($urandom_range(0, 1));
    end
    bus.clear_a_load_b = 1'b0;
    res = {dp_a, dp_b};
    chk("done_seen", int'(lat >= 0), 1);
    if (rel < 0) begin
      repeat (20) @(posedge clk);
      #1 chk("done_hold", bus.done, 1);
    end
    bus.run = 1'b0;
    @(posedge clk); #1;
    chk("idle_after", bus.done, 0);
    force_m = 1'b0;
  endtask
  initial begin
    int lat, n;
    logic [15:0] res;
    logic [7:0] b;
    bus.run = 1'b0;
    bus.clear_a_load_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_out", {bus.clr_a_load_b, bus.clr_a, bus.ld_a, bus.sub, bus.shift, bus.busy, bus.done}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.clear_a_load_b = 1'b1;
    n = 0;
    repeat (2) begin
      #4 n += int'(bus.clr_a_load_b);
      @(posedge clk); #1;
    end
    bus.clear_a_load_b = 1'b0;
    #4 n += int'(bus.clr_a_load_b);
    chk("clr_load_cycles", n, 2);
    do_mult(8'h05, 8'h00, -1, 1'b1, lat, res);
    chk("m1_lat", lat, 17);
    chk("m1_ld", n_ld, 8);
    chk("m1_sub", n_sub, 1);
    chk("m1_sh", n_sh, 8);
    do_mult(8'h07, 8'hFD, 30, 1'b0, lat, res);
    chk("p_fd_7", res, 16'hFFEB);
    chk("p_fd_7_lat", lat, exp_lat(8'hFD, 1'b0));
    do_mult(8'h80, 8'h80, -1, 1'b0, lat, res);
    chk("p_80_80", res, 16'h4000);
    chk("p_80_80_sub", n_sub, 1);
    do_mult(8'h33, 8'h5A, 30, 1'b0, lat, res);
    chk("restart_lat", lat, exp_lat(8'h5A, 1'b0));
    @(posedge clk); #1;
    sw = 8'hFF;
    bus.clear_a_load_b = 1'b1;
    @(posedge clk); #1;
    bus.clear_a_load_b = 1'b0;
    bus.run = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      n += int'(bus.shift);
      if (bus.shift && n == 5) break;
    end
    chk("mid_shift_found", n, 5);
    rst = 1'b1;
    #1 chk("mid_reset_out", {bus.clr_a_load_b, bus.clr_a, bus.ld_a, bus.sub, bus.shift, bus.busy, bus.done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.run = 1'b0;
    do_mult(8'hF6, 8'h0C, 30, 1'b0, lat, res);
    chk("post_reset_lat", lat, exp_lat(8'h0C, 1'b0));
    chk("post_reset_p", res, 16'hFF88);
    do_mult(8'h11, 8'h01, 30, 1'b0, lat, res);
    chk("b01_ld", n_ld, 1);
    chk("b01_lat", lat, SKIP ? 10 : 17);
    do_mult(8'h11, 8'h00, 30, 1'b0, lat, res);
    chk("b00_ld", n_ld, 0);
    chk("b00_sh", n_sh, 8);
    chk("b00_p", res, 16'h0000);
    for (int k = 0; k < 25; k++) begin
      b = 8'($urandom);
      do_mult(8'($urandom), b, $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 25)), 1'b0, lat, res);
      chk("rnd_lat", lat, exp_lat(b, 1'b0));
      chk("rnd_ld", n_ld, $countones(b));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        bus.clear_a_load_b = 1'($urandom_range(0, 1));
      end
      bus.clear_a_load_b = 1'b0;
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Control FSM for the 8-bit signed add-shift multiplier datapath.
- Sits directly upstream of the A/B shift-register pair and drives its control inputs: LdA, ClrA, ClrA_LoadB, Shift.
- Sequences NBITS add/shift iterations from M, the LSB of register B. The final iteration subtracts, which gives two's-complement multiplication.
- Run and ClearA_LoadB arrive already synchronized and debounced, active-high level.

Parameters:
- NBITS, 8, operand width; number of add/shift iterations per multiply.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; forces IDLE.
- Run  input  1  level; start request.
- ClearA_LoadB  input  1  level; user request to clear A and load B from switches.
- M  input  1  current LSB of register B.
- ClrA_LoadB  output  1  clear A/X and load B, to the datapath.
- ClrA  output  1  clear A and X at multiply start.
- LdA  output  1  load A/X with adder result.
- Sub  output  1  adder subtract select; qualifies LdA.
- Shift  output  1  arithmetic-shift A:B right one bit.
- Busy  output  1  multiply in progress.
- Done  output  1  result valid, held until Run released.

Behaviour:
- State register: IDLE, CLEAR, ADD, SHIFT, DONE.
- Iteration counter cnt: width $clog2(NBITS+1).
- Reset (async, any time including mid-multiply):
  - state=IDLE, cnt=0.
  - All outputs 0 from the next evaluation; no partial LdA/Shift pulse after Reset asserts.
- IDLE:
  - ClrA_LoadB = ClearA_LoadB (pass-through, this state only); all other outputs 0.
  - Run=1 -> CLEAR.
  - If Run and ClearA_LoadB are both high, ClrA_LoadB is asserted for that cycle and the FSM still goes to CLEAR.
- CLEAR:
  - ClrA=1, Busy=1; cnt<=0.
  - -> ADD unconditionally. B is untouched.
- ADD:
  - Busy=1; LdA=M.
  - Sub = M & (cnt==NBITS-1); Sub is 0 whenever LdA is 0.
  - -> SHIFT.
- SHIFT:
  - Busy=1, Shift=1; cnt<=cnt+1.
  - cnt==NBITS-1 (last shift) -> DONE; else -> ADD.
- DONE:
  - Done=1, Busy=0.
  - Stay while Run=1; Run=0 -> IDLE. Exactly one multiply per Run press.
- Outputs are combinational from the state, plus M/cnt for LdA and Sub. They are glitch-tolerant because the datapath samples them on Clk only.
- Invariant: LdA, Shift, ClrA and ClrA_LoadB are mutually exclusive in every cycle.
- Latency, without the macro: 1 (CLEAR) + 2*NBITS cycles from the first CLEAR cycle to DONE entry; 17 for NBITS=8.
- Run deasserted mid-multiply: ignored; the multiply completes, DONE is entered, then the FSM returns to IDLE the next cycle because Run=0.
- ClearA_LoadB outside IDLE: ignored; ClrA_LoadB stays 0.
- cnt never exceeds NBITS. It is held in IDLE and DONE and re-zeroed in CLEAR.

Optional Feature:
- Macro: MULT_SKIP_ADD_EN.
- Defined: the ADD state with M=0 performs the shift itself:
  - Shift=1, LdA=0, cnt<=cnt+1.
  - Next state is ADD, or DONE if cnt==NBITS-1; SHIFT is not visited.
  - With M=1, behaviour is unchanged (ADD -> SHIFT).
  - Latency = 1 + NBITS + popcount(B operand).
- Not defined: the fixed ADD/SHIFT alternation above; an ADD cycle with M=0 is an idle cycle with all datapath strobes 0.

Test Plan:
- Reset, then hold ClearA_LoadB=1 for 2 cycles in IDLE -> ClrA_LoadB=1 for exactly those 2 cycles; Busy=0, Done=0, other strobes 0.
- Run=1 with M held at 1 for all iterations -> ClrA for 1 cycle, then LdA/Shift alternate 8 times; Sub=1 only on the 8th LdA; Done rises 17 cycles after ClrA (non-macro build).
- Drive M as the LSB of a bench-modelled A:B for A=0, B=-3 (0xFD), S=7 -> datapath A:B ends at 0xFFEB (-21).
- Repeat with 0x80 x 0x80 -> result 0x4000.
- Hold Run=1 past Done for 20 cycles -> Done stays 1 and no further ClrA/LdA/Shift; drop Run -> IDLE next cycle; raise Run again -> a new multiply starts.
- Assert Reset for 1 cycle while in SHIFT with cnt=4 -> all outputs 0 immediately; next Run restarts with cnt=0 and a full 17-cycle sequence.
- MULT_SKIP_ADD_EN build, B=0x01 -> exactly 1 LdA cycle; Done 10 cycles after ClrA.
- MULT_SKIP_ADD_EN build, B=0x00 -> no LdA; 8 Shift pulses on consecutive cycles.
